// File: rtl/seq_cone_pipe_pkg.sv
// Shared types and constants for the sequential gate-cone pipeline.
// The optional scan chain is enabled with the SCAN_CHAIN_EN macro.
package seq_cone_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    localparam logic [7:0]  DEFAULT_POLY = 8'h1D;
    localparam int unsigned CONE_W       = 2;

endpackage

// File: rtl/seq_cone_pipe_if.sv
// Burst control, input beat and output beat signals of seq_cone_pipe.
// The DUT connects through the slave modport and the stimulus side through master.
interface seq_cone_pipe_if
    import seq_cone_pkg::*;
#(
    parameter int LANES = 4,
    parameter int CNT_W = 8
);

    logic                      start;
    logic [CNT_W-1:0]          len;
    logic                      in_valid;
    logic                      in_ready;
    logic [4*LANES-1:0]        a;
    logic [LANES-1:0]          b;
    logic [LANES-1:0]          c;
    logic                      out_valid;
    logic                      out_ready;
    logic [CONE_W*LANES-1:0]   f;
    logic [CONE_W*LANES-1:0]   sig;
    logic                      done;

    modport master (
        output start, len, in_valid, a, b, c, out_ready,
        input  in_ready, out_valid, f, sig, done
    );

    modport slave (
        input  start, len, in_valid, a, b, c, out_ready,
        output in_ready, out_valid, f, sig, done
    );

endinterface

// File: rtl/seq_cone_pipe_cone_lane.sv
// One lane of the fixed gate cone: a[3:0], b, c -> f[1:0], purely combinational.
module cone_lane
    import seq_cone_pkg::*;
(
    input  logic [3:0]        a_i,
    input  logic              b_i,
    input  logic              c_i,
    output logic [CONE_W-1:0] f_o
);

    logic p, q, r, s;

    assign p   = a_i[0] & a_i[1];
    assign q   = a_i[2] | a_i[3];
    assign r   = p ^ b_i;
    assign s   = q & c_i;
    assign f_o = {~(r | s), ~r};

endmodule

// File: rtl/seq_cone_pipe.sv
// LANES gate cones feeding a PIPE_DEPTH-stage valid/ready pipeline, a burst FSM and
// an output MISR. Defining SCAN_CHAIN_EN adds a scan chain over stage data and sig.
module seq_cone_pipe
    import seq_cone_pkg::*;
#(
    parameter int                      LANES      = 4,
    parameter int                      PIPE_DEPTH = 2,
    parameter int                      CNT_W      = 8,
    parameter logic [CONE_W*LANES-1:0] POLY       = (CONE_W*LANES)'(DEFAULT_POLY)
) (
    input  logic clk,
    input  logic rst_n,
`ifdef SCAN_CHAIN_EN
    input  logic scan_en,
    input  logic scan_in,
    output logic scan_out,
`endif
    seq_cone_pipe_if.slave bus
);

    localparam int W = CONE_W * LANES;

    state_e                         state_q;
    logic [CNT_W-1:0]               len_q;
    logic [CNT_W-1:0]               cnt_q;
    logic [PIPE_DEPTH-1:0]          vld_q;
    logic [PIPE_DEPTH-1:0][W-1:0]   data_q;
    logic [W-1:0]                   sig_q;
    logic [W-1:0]                   sig_d;
    logic [W-1:0]                   cone_f;

    logic scan_hold;
    logic out_valid;
    logic stall;
    logic in_hs;
    logic out_hs;
    logic start_go;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        cone_lane u_cone (
            .a_i (bus.a[4*i +: 4]),
            .b_i (bus.b[i]),
            .c_i (bus.c[i]),
            .f_o (cone_f[CONE_W*i +: CONE_W])
        );
    end

`ifdef SCAN_CHAIN_EN
    assign scan_hold = scan_en;
    assign scan_out  = sig_q[W-1];
`else
    assign scan_hold = 1'b0;
`endif

    // A stalled last stage freezes every stage; bubbles are never squeezed out.
    assign out_valid    = vld_q[PIPE_DEPTH-1] && !scan_hold;
    assign stall        = out_valid && !bus.out_ready;
    assign bus.in_ready = (state_q == RUN) && !stall && (cnt_q < len_q) && !scan_hold;
    assign in_hs        = bus.in_valid && bus.in_ready;
    assign out_hs       = out_valid && bus.out_ready;
    assign start_go     = (state_q == IDLE) && bus.start && !scan_hold;

    assign bus.out_valid = out_valid;
    assign bus.f         = data_q[PIPE_DEPTH-1];
    assign bus.sig       = sig_q;
    assign bus.done      = (state_q == DONE) && !scan_hold;

    assign sig_d = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ data_q[PIPE_DEPTH-1];

    // NOTE: all state below uses <= so every register samples pre-edge values, whatever the statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
        end else if (!scan_hold) begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= RUN;
                        len_q   <= bus.len;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    if (in_hs) cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == len_q) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (vld_q == '0) state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: stage data is reset as well as the valids, so the MISR and scan chain never see X.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= '0;
            data_q <= '0;
            sig_q  <= '0;
        end
`ifdef SCAN_CHAIN_EN
        else if (scan_en) begin
            {sig_q, data_q} <= {sig_q[W-2:0], data_q, scan_in};
        end
`endif
        else begin
            if (!stall) begin
                vld_q[0]  <= in_hs;
                data_q[0] <= cone_f;
                for (int i = 1; i < PIPE_DEPTH; i++) begin
                    vld_q[i]  <= vld_q[i-1];
                    data_q[i] <= data_q[i-1];
                end
            end
            if (start_go) begin
                sig_q <= '0;
            end else if (out_hs) begin
                sig_q <= sig_d;
            end
        end
    end

endmodule

// File: tb/tb_seq_cone_pipe.sv
// Self-checking bench for seq_cone_pipe: burst-level reference model with a
// beat scoreboard and MISR model, plus directed literal checks.
module tb_seq_cone_pipe;
    import seq_cone_pkg::*;

    localparam int LANES = 4;
    localparam int D     = 2;
    localparam int W     = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_cone_pipe_if #(.LANES(LANES), .CNT_W(8)) bus ();

`ifdef SCAN_CHAIN_EN
    logic scan_en = 1'b0;
    logic scan_in = 1'b0;
    logic scan_out;
`endif

    seq_cone_pipe #(
        .LANES      (LANES),
        .PIPE_DEPTH (D),
        .CNT_W      (8),
        .POLY       (8'h1D)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef SCAN_CHAIN_EN
        .scan_en  (scan_en),
        .scan_in  (scan_in),
        .scan_out (scan_out),
`endif
        .bus      (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference rules: per-lane cone equations and MISR step on 8-bit words.
    function automatic logic [7:0] cone_ref(input logic [15:0] a, input logic [3:0] b,
                                             input logic [3:0] c);
        logic [7:0] f;
        f = '0;
        for (int i = 0; i < LANES; i++) begin
            bit p, q, r, s;
            p = a[4*i] && a[4*i+1];
            q = a[4*i+2] || a[4*i+3];
            r = p != b[i];
            s = q && c[i];
            f[2*i]   = !r;
            f[2*i+1] = !(r || s);
        end
        return f;
    endfunction

    function automatic logic [7:0] misr_ref(input logic [7:0] s, input logic [7:0] f);
        return (s << 1) ^ (s[7] ? 8'h1D : 8'h00) ^ f;
    endfunction

    typedef struct {
        logic [7:0] f;
        int         acc_cyc;
        int         stall_snap;
    } beat_t;

    beat_t      exp_q[$];
    beat_t      e_pop, e_new;
    bit         busy, prev_stall, prev_done, stall_now, mon_pause;
    int         len_m, acc_m, cyc, stall_total, done_cnt, in_hs_total;
    int         last_lat, start_cyc, done_cyc;
    logic [7:0] sig_m, prev_f, last_f, done_sig;

    initial begin
        busy = 0; prev_stall = 0; prev_done = 0; mon_pause = 0;
        len_m = 0; acc_m = 0; cyc = 0; stall_total = 0; done_cnt = 0; in_hs_total = 0;
        last_lat = 0; start_cyc = 0; done_cyc = 0;
        sig_m = '0; prev_f = '0; last_f = '0; done_sig = '0;
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            busy = 0; exp_q.delete(); acc_m = 0; len_m = 0; sig_m = '0;
            prev_stall = 0; prev_done = 0;
        end else if (!mon_pause) begin
            stall_now = bus.out_valid && !bus.out_ready;
            if (stall_now) stall_total++;
            check("in_ready", bus.in_ready, busy && (acc_m < len_m) && !stall_now);
            if (!busy) begin
                check("idle_out_valid", bus.out_valid, 0);
                check("idle_done", bus.done, 0);
                check("idle_sig", bus.sig, sig_m);
            end
            if (prev_stall) begin
                check("stall_hold_valid", bus.out_valid, 1);
                check("stall_hold_f", bus.f, prev_f);
            end
            if (bus.out_valid && bus.out_ready) begin
                check("out_beat_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e_pop = exp_q.pop_front();
                    check("f", bus.f, e_pop.f);
                    last_lat = cyc - e_pop.acc_cyc;
                    if (stall_total == e_pop.stall_snap) check("latency", last_lat, D);
                    last_f = bus.f;
                    sig_m  = misr_ref(sig_m, e_pop.f);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e_new.f          = cone_ref(bus.a, bus.b, bus.c);
                e_new.acc_cyc    = cyc;
                e_new.stall_snap = stall_total;
                exp_q.push_back(e_new);
                acc_m++;
                in_hs_total++;
            end
            if (bus.done) begin
                check("done_pulse_width", prev_done, 0);
                check("done_sig", bus.sig, sig_m);
                check("done_beats", acc_m, len_m);
                check("done_drained", exp_q.size(), 0);
                done_sig = bus.sig;
                done_cyc = cyc;
                done_cnt++;
            end
            if (bus.start && !busy) begin
                busy = 1; len_m = int'(bus.len); acc_m = 0; sig_m = '0; start_cyc = cyc;
            end
            if (bus.done) busy = 0;
            prev_stall = stall_now;
            prev_f     = bus.f;
            prev_done  = bus.done;
        end
    end

    logic [15:0] tbl_a [16];
    logic [3:0]  tbl_b [16];
    logic [3:0]  tbl_c [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_tbl(input bit zero);
        for (int i = 0; i < 16; i++) begin
            tbl_a[i] = zero ? 16'h0 : 16'($urandom());
            tbl_b[i] = zero ? 4'h0  : 4'($urandom());
            tbl_c[i] = zero ? 4'h0  : 4'($urandom());
        end
    endtask

    // mode 0: no gaps, no stalls; 1: out_ready low for 5 cycles mid-burst;
    // 2: random gaps and stalls; 3: like 0 plus a stray start during RUN.
    task automatic run_burst(input int n, input int mode, output logic [7:0] sig_out);
        int idx, d0;
        idx = 0;
        d0  = done_cnt;
        tick();
        bus.start = 1'b1;
        bus.len   = 8'(n);
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 400 && done_cnt == d0; k++) begin
            bus.in_valid = (idx < n) && (mode != 2 || $urandom_range(0, 3) != 0);
            if (idx < n) begin
                bus.a = tbl_a[idx];
                bus.b = tbl_b[idx];
                bus.c = tbl_c[idx];
            end
            bus.start = (mode == 3) && (k == 1);
            if (mode == 3 && k == 1) bus.len = 8'd9;
            case (mode)
                1:       bus.out_ready = !(k >= 3 && k < 8);
                2:       bus.out_ready = $urandom_range(0, 3) != 0;
                default: bus.out_ready = 1'b1;
            endcase
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) idx++;
            @(posedge clk);
            #1;
        end
        if (done_cnt == d0) check("burst_done_timeout", done_cnt - d0, 1);
        check("burst_accepted", idx, n);
        sig_out       = done_sig;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [7:0] s, s1, s2;
    int         d0, st0, hs0;

    initial begin
        bus.start = 1'b1; bus.len = 8'd5; bus.in_valid = 1'b0;
        bus.a = '0; bus.b = '0; bus.c = '0; bus.out_ready = 1'b1;
        rst_n = 1'b0;

        // Reset held two edges with start high.
        repeat (2) @(posedge clk);
        #1;
        check("t1_in_ready", bus.in_ready, 0);
        check("t1_out_valid", bus.out_valid, 0);
        check("t1_done", bus.done, 0);
        check("t1_sig", bus.sig, 0);
        check("t1_state", dut.state_q, IDLE);
        rst_n     = 1'b1;
        bus.start = 1'b0;
        repeat (2) tick();

        // Single all-zero beat.
        fill_tbl(1);
        run_burst(1, 0, s);
        check("t2_sig", s, 8'hFF);
        check("t2_f", last_f, 8'hFF);
        check("t2_latency", last_lat, 2);

        // Two all-zero beats, then a single lane-0 pattern.
        run_burst(2, 0, s);
        check("t3_sig", s, 8'h1C);
        tbl_a[0] = 16'h0003; tbl_b[0] = 4'h0; tbl_c[0] = 4'h1;
        run_burst(1, 0, s);
        check("t3_lane_f", last_f, 8'hFC);
        check("t3_lane_sig", s, 8'hFC);

        // Backpressure run against the no-stall run of the same beats.
        fill_tbl(0);
        run_burst(6, 0, s1);
        st0 = stall_total;
        run_burst(6, 1, s2);
        check("t4_sig_vs_nostall", s2, s1);
        check("t4_stall_seen", (stall_total - st0) >= 5, 1);

        // Zero-length burst.
        d0  = done_cnt;
        hs0 = in_hs_total;
        tick();
        bus.start = 1'b1; bus.len = 8'd0; bus.in_valid = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 10 && done_cnt == d0; k++) @(negedge clk);
        check("t5_done_seen", done_cnt - d0, 1);
        check("t5_done_delay", (done_cyc - start_cyc) <= 3, 1);
        check("t5_sig", done_sig, 8'h00);
        check("t5_no_accept", in_hs_total - hs0, 0);
        tick();
        bus.in_valid = 1'b0;
        run_burst(3, 3, s);

        // Reset mid-burst aborts without a done.
        d0 = done_cnt;
        tick();
        bus.start = 1'b1; bus.len = 8'd8;
        tick();
        bus.start = 1'b0; bus.in_valid = 1'b1;
        bus.a = tbl_a[0]; bus.b = tbl_b[0]; bus.c = tbl_c[0];
        repeat (3) tick();
        rst_n = 1'b0; bus.in_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        check("t6_in_ready", bus.in_ready, 0);
        check("t6_out_valid", bus.out_valid, 0);
        check("t6_done", bus.done, 0);
        check("t6_sig", bus.sig, 0);
        repeat (10) tick();
        check("t6_no_done", done_cnt - d0, 0);
        fill_tbl(0);
        run_burst(5, 2, s);

        // Randomized bursts.
        for (int r = 0; r < 8; r++) begin
            fill_tbl(0);
            run_burst(int'($urandom_range(1, 12)), 2, s);
        end

`ifdef SCAN_CHAIN_EN
        begin
            logic [W+8*D-1:0] pat;
            pat = (W+8*D)'($urandom());
            mon_pause = 1;
            for (int i = 0; i < W + 8*D; i++) begin
                scan_en = 1'b1;
                scan_in = pat[i];
                bus.in_valid = 1'b1;
                @(negedge clk);
                check("scan_in_ready", bus.in_ready, 0);
                check("scan_out_valid", bus.out_valid, 0);
                check("scan_done", bus.done, 0);
                tick();
            end
            scan_in = 1'b0;
            bus.in_valid = 1'b0;
            for (int i = 0; i < W + 8*D; i++) begin
                @(negedge clk);
                check("scan_out_bit", scan_out, pat[i]);
                tick();
            end
            scan_en = 1'b0;
            rst_n = 1'b0;
            repeat (2) tick();
            rst_n = 1'b1;
            mon_pause = 0;
            check("scan_post_reset_sig", bus.sig, 0);
            fill_tbl(0);
            run_burst(4, 2, s);
        end
`endif

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
